prng_sequencer: RTL

PRNG_SEQUENCER -- requirements
Module: prng_sequencer

---
 rtl/prng_sequencer.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/prng_sequencer.sv
// ---------------------------------------------------------------------------
// prng_sequencer
//
// Control block for a two-LFSR random byte generator. A prescaler produces a
// step tick every DIV cycles while running; each tick steps the 16-bit data
// LFSR, and every SEL_DIV-th tick also steps the 8-bit select LFSR. The block
// loads seeds into the data LFSR and recovers it from the XNOR lock-up state
// (all ones). The byte that appears on the external mux after each data-LFSR
// update is captured and handed out once to one of two requesters, using
// round-robin arbitration.
//
// Ports
//   CLK          clock, single domain
//   rst          asynchronous active-low reset
//   EN           run enable; low returns the block to IDLE
//   seed_req     request to load seed_data into the data LFSR
//   seed_data    seed value
//   lfsr16_state current data-LFSR value (lock-up detection)
//   mux_byte     16-to-8 mux output, captured after each LFSR update
//   req0, req1   byte requests, level-held until granted
//   step16       data-LFSR clock enable pulse
//   step8        select-LFSR clock enable pulse
//   load16       data-LFSR parallel-load pulse
//   load_val     value to load (0 when load16 is low)
//   tick         prescaler pulse, every DIV cycles in RUN
//   gnt0, gnt1   one-cycle grant pulses
//   rnd_valid    rnd_byte valid, coincident with a grant
//   rnd_byte     delivered byte (0 when rnd_valid is low)
//   busy         high in RUN and SEED
// ---------------------------------------------------------------------------
module prng_sequencer #(
  parameter int unsigned DIV       = 50000000,
  parameter int unsigned SEL_DIV   = 4,
  parameter logic [15:0] SEED_SAFE = 16'h0000
) (
  input  logic        CLK,
  input  logic        rst,
  input  logic        EN,
  input  logic        seed_req,
  input  logic [15:0] seed_data,
  input  logic [15:0] lfsr16_state,
  input  logic [7:0]  mux_byte,
  input  logic        req0,
  input  logic        req1,
  output logic        step16,
  output logic        step8,
  output logic        load16,
  output logic [15:0] load_val,
  output logic        tick,
  output logic        gnt0,
  output logic        gnt1,
  output logic        rnd_valid,
  output logic [7:0]  rnd_byte,
  output logic        busy
);

  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int SW = (SEL_DIV > 1) ? $clog2(SEL_DIV) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(DIV - 1);
  localparam logic [SW-1:0] SEL_MAX = SW'(SEL_DIV - 1);

  typedef enum logic [1:0] {IDLE, RUN, SEED} state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   pre_q;
  logic [SW-1:0]   sel_q;
  logic            cap_pend_q;  // an LFSR update happened last cycle
  logic            avail_q;     // byte_q holds an undelivered byte
  logic [7:0]      byte_q;
  logic            last_q;      // 1: req1 was granted last, 0: req0
  logic            pick1;

  // On a tie, serve the requester that was not served last.
  assign pick1 = req1 & (~req0 | ~last_q);

  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // Next state and all outputs. Outputs depend only on the current state
  // (plus inputs), so forcing IDLE under reset forces every output to 0.
  always_comb begin
    // NOTE: every output gets a default before the case, so no path through
    // this block leaves a signal unassigned and no latch is inferred.
    state_d   = state_q;
    tick      = 1'b0;
    step16    = 1'b0;
    step8     = 1'b0;
    load16    = 1'b0;
    load_val  = 16'h0000;
    gnt0      = 1'b0;
    gnt1      = 1'b0;
    rnd_valid = 1'b0;
    rnd_byte  = 8'h00;
    busy      = 1'b0;

    unique case (state_q)
      IDLE: state_d = RUN;
      RUN: begin
        busy = 1'b1;
        if (seed_req) state_d = SEED;
        tick  = (pre_q == PRE_MAX);
        step8 = tick && (sel_q == SEL_MAX);
        // Lock-up recovery yields to a pending seed load, which happens in
        // SEED on the next cycle anyway.
        if (lfsr16_state == 16'hFFFF && !seed_req) begin
          load16   = 1'b1;
          load_val = SEED_SAFE;
        end
        // A load already rewrites the LFSR, so the step is dropped.
        step16 = tick && !load16;
        if (avail_q && (req0 || req1)) begin
          rnd_valid = 1'b1;
          rnd_byte  = byte_q;
          gnt1      = pick1;
          gnt0      = !pick1;
        end
      end
      SEED: begin
        busy     = 1'b1;
        state_d  = RUN;
        load16   = 1'b1;
        load_val = (seed_data == 16'hFFFF) ? SEED_SAFE : seed_data;
      end
      default: state_d = IDLE;
    endcase

    if (!EN) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples the pre-edge values of the others.
  always_ff @(posedge CLK or negedge rst) begin
    if (!rst) begin
      pre_q      <= '0;
      sel_q      <= '0;
      cap_pend_q <= 1'b0;
      avail_q    <= 1'b0;
      byte_q     <= 8'h00;
      last_q     <= 1'b1;
    end else begin
      // The pointer survives EN=0 so fairness carries across pauses.
      if (rnd_valid) last_q <= gnt1;

      if (!EN || state_q != RUN) begin
        pre_q <= '0;
        sel_q <= '0;
      end else if (tick) begin
        pre_q <= '0;
        sel_q <= (sel_q == SEL_MAX) ? '0 : sel_q + SW'(1);
      end else begin
        pre_q <= pre_q + PW'(1);
      end

      if (!EN) begin
        cap_pend_q <= 1'b0;
        avail_q    <= 1'b0;
      end else begin
        cap_pend_q <= step16 | load16;
        // A capture in the same cycle as a grant wins: the grant takes the
        // old byte and the new one stays available.
        if (cap_pend_q) begin
          byte_q  <= mux_byte;
          avail_q <= 1'b1;
        end else if (rnd_valid) begin
          avail_q <= 1'b0;
        end
      end
    end
  end

endmodule
